// File: rtl/ram_sp_clr.sv
// rtl/ram_sp_clr.sv - parametrised single-port synchronous RAM with hardware clear engine
//
// Ports:
//   clk       - clock, all logic on the rising edge
//   reset     - synchronous active-high reset (array contents untouched)
//   req       - access request, sampled every cycle
//   load      - write enable, qualified by req
//   address   - word address
//   in        - write data
//   clear     - pulse: start a full-array clear
//   out       - read data, holds its last value between reads
//   out_valid - one-cycle strobe per accepted req
//   busy      - high while the clear engine owns the array

module ram_sp_clr #(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 14,
  parameter int RDW_MODE       = 0,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] in,
  input  logic              clear,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rd_word;
  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;

  assign busy = (state == CLEAR);

  // A clear request in IDLE takes priority over a simultaneous access.
  assign accept = !reset && (state == IDLE) && req && !clear;

  // Single write port shared between the clear engine and user writes.
  // Reset never writes, so an aborted clear leaves the array as it was.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = address;
    mem_wdata = in;
    if (!reset) begin
      if (state == CLEAR) begin
        mem_we    = 1'b1;
        mem_addr  = clr_cnt;
        mem_wdata = '0;
      end else if (accept && load) begin
        mem_we = 1'b1;
      end
    end
  end

  // Read-first returns the pre-write word; write-first forwards the write data.
  always_comb begin
    rd_word = mem[address];
    if ((RDW_MODE != 0) && load) begin
      rd_word = in;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      clr_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clear) begin
            state   <= CLEAR;
            clr_cnt <= '0;
          end
        end
        CLEAR: begin
          // Clear requests here are ignored; the sweep always runs to the end.
          if (&clr_cnt) begin
            state   <= IDLE;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + ADDR_W'(1);
          end
        end
      endcase
    end
  end

  // Read pipeline: s1 is the array output register; with OUT_REG set, out is
  // a second stage fed from s1, otherwise out is loaded directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_data <= rd_word;
      end
      if (OUT_REG != 0) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out <= s1_data;
        end
      end else begin
        out_valid <= accept;
        if (accept) begin
          out <= rd_word;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_sp_clr.sv
// tb/tb_ram_sp_clr.sv - self-checking bench for ram_sp_clr (three configurations)
//
// u_a: ADDR_W=4, read-first, latency 1, clear on reset
// u_b: ADDR_W=4, write-first, latency 2, no clear on reset
// u_c: default parameters

module tb_ram_sp_clr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset [3];
  logic        req [3];
  logic        load [3];
  logic        clear [3];
  logic [13:0] address [3];
  logic [15:0] din [3];
  logic [15:0] out [3];
  logic        out_valid [3];
  logic        busy [3];

  int checks   = 0;
  int failures = 0;

  ram_sp_clr #(.DATA_W(16), .ADDR_W(4), .RDW_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(1)) u_a (
    .clk(clk), .reset(reset[0]), .req(req[0]), .load(load[0]), .address(address[0][3:0]),
    .in(din[0]), .clear(clear[0]), .out(out[0]), .out_valid(out_valid[0]), .busy(busy[0])
  );

  ram_sp_clr #(.DATA_W(16), .ADDR_W(4), .RDW_MODE(1), .OUT_REG(1), .CLEAR_ON_RESET(0)) u_b (
    .clk(clk), .reset(reset[1]), .req(req[1]), .load(load[1]), .address(address[1][3:0]),
    .in(din[1]), .clear(clear[1]), .out(out[1]), .out_valid(out_valid[1]), .busy(busy[1])
  );

  ram_sp_clr u_c (
    .clk(clk), .reset(reset[2]), .req(req[2]), .load(load[2]), .address(address[2]),
    .in(din[2]), .clear(clear[2]), .out(out[2]), .out_valid(out_valid[2]), .busy(busy[2])
  );

  typedef struct {
    logic        req;
    logic        load;
    logic [13:0] addr;
    logic [15:0] din;
    logic        ev;
    logic [15:0] eo;
  } vec_t;

  vec_t tv [25];

  function automatic vec_t mk(input logic r, input logic l, input logic [13:0] a,
                              input logic [15:0] d, input logic ev, input logic [15:0] eo);
    vec_t v;
    v.req = r; v.load = l; v.addr = a; v.din = d; v.ev = ev; v.eo = eo;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input int k, input logic r, input logic l, input logic [13:0] a,
                       input logic [15:0] d, input logic c);
    req[k] = r; load[k] = l; address[k] = a; din[k] = d; clear[k] = c;
  endtask

  // One access, then checks the strobe timing, data and single-cycle width.
  task automatic acc(input int k, input logic l, input logic [13:0] a, input logic [15:0] d,
                     input logic [15:0] e, input int lat, input string nm);
    drive(k, 1'b1, l, a, d, 1'b0);
    @(negedge clk);
    drive(k, 1'b0, 1'b0, 14'd0, 16'h0, 1'b0);
    if (lat == 2) begin
      chk({nm, "_early"}, 32'(out_valid[k]), 32'd0);
      @(negedge clk);
    end
    chk({nm, "_valid"}, 32'(out_valid[k]), 32'd1);
    chk({nm, "_data"}, 32'(out[k]), 32'(e));
    @(negedge clk);
    chk({nm, "_strobe_once"}, 32'(out_valid[k]), 32'd0);
  endtask

  task automatic wr(input int k, input logic [13:0] a, input logic [15:0] d);
    drive(k, 1'b1, 1'b1, a, d, 1'b0);
    @(negedge clk);
    drive(k, 1'b0, 1'b0, 14'd0, 16'h0, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_busy(input int k, input int bound, input int exp, input string nm);
    int n;
    n = 0;
    while (busy[k] && n < bound) begin
      n++;
      @(negedge clk);
    end
    chk(nm, 32'(n), 32'(exp));
  endtask

  initial begin
    int n;
    int nv;
    logic exp_rb [3];
    exp_rb[0] = 1'b1; exp_rb[1] = 1'b0; exp_rb[2] = 1'b1;

    tv[0]  = mk(1'b1, 1'b0, 14'd0,  16'h0000, 1'b1, 16'h0000);
    tv[1]  = mk(1'b1, 1'b0, 14'd15, 16'h0000, 1'b1, 16'h0000);
    tv[2]  = mk(1'b1, 1'b1, 14'd5,  16'h1111, 1'b1, 16'h0000);
    tv[3]  = mk(1'b1, 1'b1, 14'd5,  16'h2222, 1'b1, 16'h1111);
    tv[4]  = mk(1'b1, 1'b0, 14'd5,  16'h0000, 1'b1, 16'h2222);
    tv[5]  = mk(1'b0, 1'b0, 14'd0,  16'h0000, 1'b0, 16'h2222);
    tv[6]  = mk(1'b1, 1'b1, 14'd3,  16'hAAAA, 1'b1, 16'h0000);
    tv[7]  = mk(1'b1, 1'b0, 14'd3,  16'h0000, 1'b1, 16'hAAAA);
    tv[8]  = mk(1'b1, 1'b1, 14'd0,  16'h0100, 1'b1, 16'h0000);
    tv[9]  = mk(1'b1, 1'b1, 14'd1,  16'h0101, 1'b1, 16'h0000);
    tv[10] = mk(1'b1, 1'b1, 14'd2,  16'h0102, 1'b1, 16'h0000);
    tv[11] = mk(1'b1, 1'b1, 14'd3,  16'h0103, 1'b1, 16'hAAAA);
    tv[12] = mk(1'b1, 1'b1, 14'd4,  16'h0104, 1'b1, 16'h0000);
    tv[13] = mk(1'b1, 1'b1, 14'd5,  16'h0105, 1'b1, 16'h2222);
    tv[14] = mk(1'b1, 1'b1, 14'd6,  16'h0106, 1'b1, 16'h0000);
    tv[15] = mk(1'b1, 1'b1, 14'd7,  16'h0107, 1'b1, 16'h0000);
    tv[16] = mk(1'b1, 1'b0, 14'd0,  16'h0000, 1'b1, 16'h0100);
    tv[17] = mk(1'b1, 1'b0, 14'd1,  16'h0000, 1'b1, 16'h0101);
    tv[18] = mk(1'b1, 1'b0, 14'd2,  16'h0000, 1'b1, 16'h0102);
    tv[19] = mk(1'b1, 1'b0, 14'd3,  16'h0000, 1'b1, 16'h0103);
    tv[20] = mk(1'b1, 1'b0, 14'd4,  16'h0000, 1'b1, 16'h0104);
    tv[21] = mk(1'b1, 1'b0, 14'd5,  16'h0000, 1'b1, 16'h0105);
    tv[22] = mk(1'b1, 1'b0, 14'd6,  16'h0000, 1'b1, 16'h0106);
    tv[23] = mk(1'b1, 1'b0, 14'd7,  16'h0000, 1'b1, 16'h0107);
    tv[24] = mk(1'b0, 1'b0, 14'd0,  16'h0000, 1'b0, 16'h0107);

    for (int k = 0; k < 3; k++) begin
      reset[k] = 1'b1;
      drive(k, 1'b0, 1'b0, 14'd0, 16'h0, 1'b0);
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("reset_out", 32'(out[k]), 32'd0);
      chk("reset_valid", 32'(out_valid[k]), 32'd0);
      chk("reset_busy", 32'(busy[k]), 32'(exp_rb[k]));
    end

    // u_a: automatic clear after reset, then every word reads zero.
    reset[0] = 1'b0;
    wait_busy(0, 100, 16, "a_init_clear_len");
    for (int i = 0; i < 16; i++) acc(0, 1'b0, 14'(i), 16'h0, 16'h0000, 1, "a_zero");

    // u_a: table of reads, read-first writes and a streaming burst.
    for (int i = 0; i < 25; i++) begin
      drive(0, tv[i].req, tv[i].load, tv[i].addr, tv[i].din, 1'b0);
      @(negedge clk);
      chk($sformatf("a_tv%0d_valid", i), 32'(out_valid[0]), 32'(tv[i].ev));
      chk($sformatf("a_tv%0d_data", i), 32'(out[0]), 32'(tv[i].eo));
      chk($sformatf("a_tv%0d_busy", i), 32'(busy[0]), 32'd0);
    end
    drive(0, 1'b0, 1'b0, 14'd0, 16'h0, 1'b0);

    // u_a: clear beats a simultaneous write; reqs and clears during busy are ignored.
    for (int i = 0; i < 16; i++) wr(0, 14'(i), 16'hAAAA);
    drive(0, 1'b1, 1'b1, 14'd3, 16'h5555, 1'b1);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 14'd0, 16'h0, 1'b0);
    chk("a_clr_req_dropped", 32'(out_valid[0]), 32'd0);
    n = 0;
    nv = 0;
    while (busy[0] && n < 100) begin
      n++;
      drive(0, 1'b1, 1'b0, 14'(n % 16), 16'h0, n == 5);
      @(negedge clk);
      if (out_valid[0]) nv++;
    end
    drive(0, 1'b0, 1'b0, 14'd0, 16'h0, 1'b0);
    chk("a_cmd_clear_len", 32'(n), 32'd16);
    chk("a_valid_during_busy", 32'(nv), 32'd0);
    acc(0, 1'b0, 14'd3, 16'h0, 16'h0000, 1, "a_after_clear_w3");
    acc(0, 1'b0, 14'd15, 16'h0, 16'h0000, 1, "a_after_clear_w15");

    // u_a: reset in the middle of a clear restarts a full-length clear.
    drive(0, 1'b0, 1'b0, 14'd0, 16'h0, 1'b1);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 14'd0, 16'h0, 1'b0);
    repeat (7) @(negedge clk);
    chk("a_mid_clear_busy", 32'(busy[0]), 32'd1);
    reset[0] = 1'b1;
    @(negedge clk);
    reset[0] = 1'b0;
    wait_busy(0, 100, 16, "a_restart_clear_len");

    // u_b: no automatic clear, latency 2, write-first.
    reset[1] = 1'b0;
    @(negedge clk);
    chk("b_no_auto_clear", 32'(busy[1]), 32'd0);
    wr(1, 14'd4, 16'hBEEF);
    acc(1, 1'b0, 14'd4, 16'h0, 16'hBEEF, 2, "b_beef");
    wr(1, 14'd5, 16'h1111);
    acc(1, 1'b1, 14'd5, 16'h2222, 16'h2222, 2, "b_rdw_write_first");
    acc(1, 1'b0, 14'd5, 16'h0, 16'h2222, 2, "b_rdw_after");

    // u_b: reset aborts a clear after words 0..6, leaving 7..15 intact.
    for (int i = 0; i < 16; i++) wr(1, 14'(i), 16'hAAAA);
    drive(1, 1'b0, 1'b0, 14'd0, 16'h0, 1'b1);
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 14'd0, 16'h0, 1'b0);
    chk("b_clear_started", 32'(busy[1]), 32'd1);
    repeat (7) @(negedge clk);
    reset[1] = 1'b1;
    @(negedge clk);
    reset[1] = 1'b0;
    chk("b_abort_busy", 32'(busy[1]), 32'd0);
    @(negedge clk);
    chk("b_abort_busy_stays", 32'(busy[1]), 32'd0);
    for (int i = 0; i < 16; i++)
      acc(1, 1'b0, 14'(i), 16'h0, (i < 7) ? 16'h0000 : 16'hAAAA, 2, $sformatf("b_partial%0d", i));

    // u_c: default configuration, full-depth clear then a write/read.
    reset[2] = 1'b0;
    wait_busy(2, 20000, 16384, "c_init_clear_len");
    wr(2, 14'h1234, 16'hBEEF);
    acc(2, 1'b0, 14'h1234, 16'h0, 16'hBEEF, 1, "c_beef");
    acc(2, 1'b0, 14'h1233, 16'h0, 16'h0000, 1, "c_neighbor");
    acc(2, 1'b0, 14'h3FFF, 16'h0, 16'h0000, 1, "c_top_word");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_sp_clr.md
Name: ram_sp_clr

Overview:
Parametrised single-port synchronous RAM, the next generation of the fixed 16K x 16 Hack data RAM. It generalises width and depth and adds a selectable read-during-write mode and an optional output pipeline register. It also has a hardware clear engine that zeroes every word after reset or on command, so software never sees uninitialised memory. The block sits behind the CPU data bus or the screen/scratch memory map.

Parameters:
DATA_W, 16, word width in bits.
ADDR_W, 14, address width; DEPTH = 2**ADDR_W words.
RDW_MODE, 0, read-during-write to the same address: 0 = read-first (returns old data), 1 = write-first (returns new data).
OUT_REG, 0, 0 = read latency 1; 1 = extra output register, read latency 2.
CLEAR_ON_RESET, 1, 1 = start a full clear automatically when reset deasserts.

Ports:
clk  in  1  clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
req  in  1  access request, sampled each cycle.
load  in  1  write enable; qualified by req.
address  in  ADDR_W  word address.
in  in  DATA_W  write data.
clear  in  1  pulse: start a full memory clear.
out  out  DATA_W  read data.
out_valid  out  1  one-cycle strobe: out carries the data for an accepted req.
busy  out  1  high while the clear engine owns the array.

Behaviour:
- Reset: reset is synchronous, active-high; the clock is clk.
  - While reset is high: out = 0, out_valid = 0, the pipeline stage is cleared, clear counter = 0.
  - State while reset is high: CLEAR with busy = 1 if CLEAR_ON_RESET = 1, else IDLE with busy = 0.
  - Array contents are not touched by reset itself.
- FSM has two states, IDLE and CLEAR.
- IDLE:
  - req = 1 is accepted.
  - If load = 1, memory[address] <= in at the edge.
  - Read data is captured at the same edge.
  - clear = 1 moves to CLEAR with counter = 0 and busy = 1 from the next cycle.
- CLEAR:
  - Each cycle: memory[counter] <= 0, counter increments.
  - On the cycle counter = DEPTH-1, the last word is written and the next state is IDLE.
  - The clear takes exactly DEPTH cycles; busy is high for exactly DEPTH cycles.
  - req is ignored while busy: no write, no out_valid.
  - clear is ignored while busy; the in-progress clear is not restarted.
- Simultaneous req and clear in IDLE: clear wins; req is dropped with no write and no out_valid.
- Reset mid-clear: the counter returns to 0; the clear restarts if CLEAR_ON_RESET = 1, otherwise it aborts with a partially cleared array.
- Read latency:
  - req accepted at edge N: out and out_valid are valid after edge N+1 (OUT_REG = 0) or N+2 (OUT_REG = 1).
  - out_valid is high for exactly one cycle per accepted req.
  - Back-to-back reqs give back-to-back strobes; full throughput, one access per cycle.
- out holds its last value when no read completes, and while busy.
- Read-during-write to the same address:
  - RDW_MODE = 0: out = pre-write contents.
  - RDW_MODE = 1: out = in.
- Writes (load = 1 with req) also produce a read strobe according to the RDW_MODE rules.
- Addresses use the full ADDR_W range; no out-of-range case exists. The clear counter wraps to 0 only via the FSM exit.

Test Plan:
- ADDR_W = 4, CLEAR_ON_RESET = 1: deassert reset -> busy high for exactly 16 cycles, then low; reading all 16 addresses returns 0x0000.
- Defaults, after clear: write 0xBEEF to 0x1234, then read 0x1234 -> out = 0xBEEF with out_valid one cycle after the read req. With OUT_REG = 1, the same result arrives two cycles after the req.
- Same-address read-during-write: address 5 holds 0x1111, write 0x2222 to address 5 -> out = 0x1111 (RDW_MODE = 0) or 0x2222 (RDW_MODE = 1). A following read returns 0x2222 in both modes.
- ADDR_W = 4, data 0xAAAA in all words: pulse clear together with a req write of 0x5555 to address 3 -> write dropped, no out_valid, busy high for 16 cycles, address 3 reads 0x0000 afterwards. A req issued during busy produces no out_valid.
- ADDR_W = 4: assert reset at cycle 7 of a clear -> after reset deasserts, busy stays high a fresh 16 cycles. With CLEAR_ON_RESET = 0, busy is 0 immediately and words 7..15 keep their old values.
- Streaming: 8 back-to-back reads of addresses 0..7 holding 0x0100+i -> 8 consecutive out_valid cycles, out = 0x0100..0x0107 in order.
